// File: rtl/switch_pkg.sv
// Shared definitions for the switch toggle bank: edge-mode encodings and helpers.
package switch_pkg;

  localparam int unsigned EDGE_RELEASE = 0;
  localparam int unsigned EDGE_PRESS   = 1;
  localparam int unsigned EDGE_BOTH    = 2;

  // Counter wide enough to hold 0 .. limit-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // True when an accepted transition to new_level is a trigger for the given mode.
  function automatic logic edge_qualifies(input int unsigned mode, input logic new_level);
    logic q;
    q = 1'b0;
    case (mode)
      EDGE_RELEASE: q = ~new_level;
      EDGE_PRESS:   q = new_level;
      EDGE_BOTH:    q = 1'b1;
      default:      q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/switch_debounce_ch.sv
// One switch channel: 2-flop synchroniser, stable-count debounce filter and
// a combinational accept strobe marking the edge at which o_Debounced updates.
module switch_debounce_ch
  import switch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Debounced,
  output logic o_Accept_c
);

  localparam int unsigned     CNT_W    = cnt_width(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [1:0]       r_sync_chain;
  logic             r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             r_debounced;
  logic             debounced_nxt;
  logic             accept_c;

  assign r_sync = r_sync_chain[1];

  // Metastability guard on the raw pin.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_sync_chain <= 2'b00;
    end else begin
      r_sync_chain <= {r_sync_chain[0], i_Switch};
    end
  end

  // Count consecutive cycles that the synchronised level differs from the accepted one.
  always_comb begin
    cnt_nxt       = r_cnt;
    debounced_nxt = r_debounced;
    accept_c      = 1'b0;
    if (r_sync == r_debounced) begin
      cnt_nxt = '0;
    end else if (r_cnt == CNT_LAST) begin
      cnt_nxt       = '0;
      debounced_nxt = r_sync;
      accept_c      = 1'b1;
    end else begin
      cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_cnt       <= '0;
      r_debounced <= 1'b0;
    end else begin
      r_cnt       <= cnt_nxt;
      r_debounced <= debounced_nxt;
    end
  end

  assign o_Debounced = r_debounced;
  assign o_Accept_c  = accept_c;

endmodule

// File: rtl/switch_toggle_bank.sv
// N-channel debounced switch-to-LED toggler. Optional registered edge pulses
// are built in when SWITCH_TOGGLE_PULSE_EN is defined.
module switch_toggle_bank
  import switch_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned EDGE_MODE      = 0
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic [NUM_CH-1:0] i_Led_Clear,
`ifdef SWITCH_TOGGLE_PULSE_EN
  output logic [NUM_CH-1:0] o_Edge_Pulse,
`endif
  output logic [NUM_CH-1:0] o_Debounced,
  output logic [NUM_CH-1:0] o_Led
);

  logic [NUM_CH-1:0] debounced;
  logic [NUM_CH-1:0] accept_c;
  logic [NUM_CH-1:0] qualify_c;
  logic [NUM_CH-1:0] r_led;
  logic [NUM_CH-1:0] led_nxt;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    switch_debounce_ch #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_ch (
      .i_Clk      (i_Clk),
      .i_Reset    (i_Reset),
      .i_Switch   (i_Switch[ch]),
      .o_Debounced(debounced[ch]),
      .o_Accept_c (accept_c[ch])
    );
  end

  // On accept the new level is the inverse of the currently held level.
  always_comb begin
    qualify_c = '0;
    led_nxt   = r_led;
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      qualify_c[ch] = accept_c[ch] & edge_qualifies(EDGE_MODE, ~debounced[ch]);
      if (i_Led_Clear[ch]) begin
        led_nxt[ch] = 1'b0;
      end else if (qualify_c[ch]) begin
        led_nxt[ch] = ~r_led[ch];
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_led <= '0;
    end else begin
      r_led <= led_nxt;
    end
  end

`ifdef SWITCH_TOGGLE_PULSE_EN
  logic [NUM_CH-1:0] r_pulse;

  // Pulse follows the qualifying edge only; LED clear does not suppress it.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_pulse <= '0;
    end else begin
      r_pulse <= qualify_c;
    end
  end

  assign o_Edge_Pulse = r_pulse;
`endif

  assign o_Debounced = debounced;
  assign o_Led       = r_led;

endmodule

// File: tb/tb_switch_toggle_bank.sv
// Bench for switch_toggle_bank: three instances (release, press, both-edge
// modes) sharing stimulus, compared against a behavioural reference every cycle.
module tb_switch_toggle_bank;

  localparam int unsigned NCH = 2;
  localparam int unsigned LIM = 4;
  localparam int unsigned LAT = 2 + LIM;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] sw;
  logic [NCH-1:0] clr;

  logic [NCH-1:0] deb_o [3];
  logic [NCH-1:0] led_o [3];
`ifdef SWITCH_TOGGLE_PULSE_EN
  logic [NCH-1:0] pulse_o [3];
`endif

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    switch_toggle_bank #(
      .NUM_CH(NCH), .DEBOUNCE_LIMIT(LIM), .EDGE_MODE(m)
    ) u_dut (
      .i_Clk       (clk),
      .i_Reset     (rst),
      .i_Switch    (sw),
      .i_Led_Clear (clr),
`ifdef SWITCH_TOGGLE_PULSE_EN
      .o_Edge_Pulse(pulse_o[m]),
`endif
      .o_Debounced (deb_o[m]),
      .o_Led       (led_o[m])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: pin image two cycles late, length of current disagreement run.
  logic [NCH-1:0] m_pin_d1, m_pin_d2, m_deb;
  int             m_run [NCH];
  logic [NCH-1:0] m_led [3];
  logic [NCH-1:0] m_pulse [3];

  task automatic chk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic [NCH-1:0] s, input logic [NCH-1:0] c, input logic r);
    logic acc, lvl, trig;
    if (r) begin
      m_pin_d1 = '0; m_pin_d2 = '0; m_deb = '0;
      for (int ch = 0; ch < int'(NCH); ch++) m_run[ch] = 0;
      for (int m = 0; m < 3; m++) begin m_led[m] = '0; m_pulse[m] = '0; end
      return;
    end
    for (int ch = 0; ch < int'(NCH); ch++) begin
      acc = 1'b0;
      lvl = m_pin_d2[ch];
      if (lvl != m_deb[ch]) begin
        m_run[ch] = m_run[ch] + 1;
        if (m_run[ch] >= int'(LIM)) begin
          acc = 1'b1; m_deb[ch] = lvl; m_run[ch] = 0;
        end
      end else begin
        m_run[ch] = 0;
      end
      for (int m = 0; m < 3; m++) begin
        trig = acc && ((m == 2) || (m == 1 && lvl) || (m == 0 && !lvl));
        m_pulse[m][ch] = trig;
        if (c[ch]) m_led[m][ch] = 1'b0;
        else if (trig) m_led[m][ch] = ~m_led[m][ch];
      end
    end
    m_pin_d2 = m_pin_d1;
    m_pin_d1 = s;
  endtask

  task automatic cycle();
    logic [NCH-1:0] s, c;
    logic r;
    s = sw; c = clr; r = rst;
    @(posedge clk);
    model_step(s, c, r);
    @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("model_deb_m%0d", m), deb_o[m], m_deb);
      chk($sformatf("model_led_m%0d", m), led_o[m], m_led[m]);
`ifdef SWITCH_TOGGLE_PULSE_EN
      chk($sformatf("model_pulse_m%0d", m), pulse_o[m], m_pulse[m]);
`endif
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  typedef struct {
    logic [NCH-1:0] sw;
    logic [NCH-1:0] clr;
    int             cyc;
    logic [NCH-1:0] exp_deb;
    logic [NCH-1:0] exp_l0;
    logic [NCH-1:0] exp_l1;
    logic [NCH-1:0] exp_l2;
  } vec_t;

  vec_t tbl [15];
  int   hold [NCH];

  initial begin
    tbl[0]  = '{2'b01, 2'b00, 6, 2'b01, 2'b00, 2'b01, 2'b01};
    tbl[1]  = '{2'b00, 2'b00, 6, 2'b00, 2'b01, 2'b01, 2'b00};
    tbl[2]  = '{2'b01, 2'b00, 6, 2'b01, 2'b01, 2'b00, 2'b01};
    tbl[3]  = '{2'b00, 2'b00, 6, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[4]  = '{2'b10, 2'b00, 3, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[5]  = '{2'b00, 2'b00, 8, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[6]  = '{2'b10, 2'b00, 6, 2'b10, 2'b00, 2'b10, 2'b10};
    tbl[7]  = '{2'b00, 2'b00, 6, 2'b00, 2'b10, 2'b10, 2'b00};
    tbl[8]  = '{2'b11, 2'b00, 6, 2'b11, 2'b10, 2'b01, 2'b11};
    tbl[9]  = '{2'b00, 2'b00, 6, 2'b00, 2'b01, 2'b01, 2'b00};
    tbl[10] = '{2'b00, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[11] = '{2'b01, 2'b00, 6, 2'b01, 2'b00, 2'b01, 2'b01};
    tbl[12] = '{2'b00, 2'b00, 5, 2'b01, 2'b00, 2'b01, 2'b01};
    tbl[13] = '{2'b00, 2'b01, 1, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[14] = '{2'b00, 2'b00, 2, 2'b00, 2'b00, 2'b00, 2'b00};

    rst = 1'b1; sw = 2'b11; clr = 2'b00;
    model_step(sw, clr, 1'b1);
    @(negedge clk);

    // Reset held with switches high: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("reset_deb", deb_o[0], 2'b00);
      chk("reset_led", led_o[0], 2'b00);
    end
    rst = 1'b0;
    run(LAT - 1);
    chk("post_reset_deb_early", deb_o[0], 2'b00);
    cycle();
    chk("post_reset_deb_lat", deb_o[0], 2'b11);
    chk("post_reset_led_m0", led_o[0], 2'b00);
    chk("post_reset_led_m1", led_o[1], 2'b11);

    // Clean start for the directed table.
    rst = 1'b1; sw = 2'b00;
    run(2);
    rst = 1'b0;
    run(3);

    foreach (tbl[k]) begin
      sw = tbl[k].sw; clr = tbl[k].clr;
      run(tbl[k].cyc);
`ifdef SWITCH_TOGGLE_PULSE_EN
      if (k == 13) chk("clear_pulse_m0", pulse_o[0], 2'b01);
`endif
      chk($sformatf("tbl%0d_deb", k), deb_o[0], tbl[k].exp_deb);
      chk($sformatf("tbl%0d_led_m0", k), led_o[0], tbl[k].exp_l0);
      chk($sformatf("tbl%0d_led_m1", k), led_o[1], tbl[k].exp_l1);
      chk($sformatf("tbl%0d_led_m2", k), led_o[2], tbl[k].exp_l2);
    end
    clr = 2'b00;

    // Reset two cycles into a pending change discards the partial count.
    sw = 2'b01;
    run(2);
    rst = 1'b1;
    run(2);
    chk("midcount_deb_in_reset", deb_o[0], 2'b00);
    rst = 1'b0;
    run(LAT - 1);
    chk("midcount_deb_early", deb_o[0], 2'b00);
    cycle();
    chk("midcount_deb_lat", deb_o[0], 2'b01);

    // Randomised run with per-channel hold times around the debounce limit.
    for (int ch = 0; ch < int'(NCH); ch++) hold[ch] = 1;
    for (int i = 0; i < 800; i++) begin
      for (int ch = 0; ch < int'(NCH); ch++) begin
        hold[ch] = hold[ch] - 1;
        if (hold[ch] <= 0) begin
          sw[ch]   = ~sw[ch];
          hold[ch] = int'($urandom_range(1, 9));
        end
      end
      clr = ($urandom_range(0, 11) == 0) ? NCH'($urandom) : '0;
      rst = ($urandom_range(0, 249) == 0);
      cycle();
    end
    rst = 1'b0; clr = '0;
    run(LAT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
